// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIB_W       width of one adder stage slice (4 bits)
//   state_t     control FSM states (IDLE, RUN, DONE)
//   nibbles_of  number of nibble slices in an operand of a given width
//   idx_width   width of the nibble index counter, at least 1 bit
package nibble_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nibbles_of(input int width);
    return width / NIB_W;
  endfunction

  // A single-nibble build still needs a 1-bit index register.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 1) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit adder slice.
//   a4, b4  operand nibbles
//   ci      carry in
//   s4      nibble sum
//   co      carry out of bit 3
//   c3      carry into bit 3 (needed for signed overflow on the top nibble)
module nibble_add4 (
  input  logic [3:0] a4,
  input  logic [3:0] b4,
  input  logic       ci,
  output logic [3:0] s4,
  output logic       co,
  output logic       c3
);

  logic [4:0] full_sum;
  logic [3:0] low_sum;

  assign full_sum = {1'b0, a4} + {1'b0, b4} + {4'b0000, ci};
  // Sum of the low three bits; its bit 3 is exactly the carry into bit 3.
  assign low_sum  = {1'b0, a4[2:0]} + {1'b0, b4[2:0]} + {3'b000, ci};

  assign s4 = full_sum[3:0];
  assign co = full_sum[4];
  assign c3 = low_sum[3];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around one 4-bit adder slice.
// Operands are accepted on a valid/ready handshake, added one nibble per
// cycle LSB first with the carry held in a register, and the result is
// offered on a second valid/ready handshake.
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid/in_ready    operand handshake (ready only in IDLE)
//   a, b, cin            operands and carry in
//   out_valid/out_ready  result handshake (valid only in DONE)
//   sum, cout, ovf       a+b+cin mod 2^WIDTH, carry out, signed overflow
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIBBLES = nibbles_of(WIDTH);
  localparam int IW      = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic             ovf_reg;
  logic [IW-1:0]    idx_reg;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] s_nib;
  logic             co_nib;
  logic             c3_nib;

  // Operand nibble select driven by the index register.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_reg == IW'(i)) begin
        a_nib = a_reg[i*NIB_W +: NIB_W];
        b_nib = b_reg[i*NIB_W +: NIB_W];
      end
    end
  end

  nibble_add4 u_add4 (
    .a4 (a_nib),
    .b4 (b_nib),
    .ci (carry_reg),
    .s4 (s_nib),
    .co (co_nib),
    .c3 (c3_nib)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_reg == IW'(i)) begin
              sum_reg[i*NIB_W +: NIB_W] <= s_nib;
            end
          end
          carry_reg <= co_nib;
          if (idx_reg == LAST_IDX) begin
            // Top nibble: carry into the MSB vs. carry out gives overflow.
            cout_reg  <= co_nib;
            ovf_reg   <= c3_nib ^ co_nib;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  logic        w4_in_valid = 1'b0;
  logic        w4_in_ready;
  logic [3:0]  w4_a = '0;
  logic [3:0]  w4_b = '0;
  logic        w4_cin = 1'b0;
  logic        w4_out_valid;
  logic        w4_out_ready = 1'b0;
  logic [3:0]  w4_sum;
  logic        w4_cout;
  logic        w4_ovf;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w4_in_valid), .in_ready(w4_in_ready),
    .a(w4_a), .b(w4_b), .cin(w4_cin),
    .out_valid(w4_out_valid), .out_ready(w4_out_ready),
    .sum(w4_sum), .cout(w4_cout), .ovf(w4_ovf)
  );

  // Reference: full-width add, overflow from operand/result signs.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    logic [16:0] full;
    exp_t e;
    full = {1'b0, x} + {1'b0, y} + {16'b0, c};
    e.s = full[15:0];
    e.c = full[16];
    e.o = (x[15] == y[15]) && (full[15] != x[15]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, let the accept edge happen, push the expectation.
  task automatic accept(input logic [15:0] x, input logic [15:0] y, input logic c);
    int guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      tick();
      guard++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_ready: in_ready=%b required 1 within 40 cycles", in_ready);
    end
    a = x; b = y; cin = c; in_valid = 1'b1;
    sb.push_back(model(x, y, c));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    checks++;
    if (!out_valid) begin
      errors++;
      $display("FAIL wait_out: out_valid=%b required 1 within 40 cycles", out_valid);
    end
  endtask

  task automatic compare_result(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_scoreboard: queue empty, required one entry", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (sum !== e.s || cout !== e.c || ovf !== e.o) begin
      errors++;
      $display("FAIL %s: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
               name, sum, cout, ovf, e.s, e.c, e.o);
    end else begin
      $display("op %s: sum=%h cout=%b ovf=%b ok", name, sum, cout, ovf);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y, input logic c);
    int cyc;
    accept(x, y, c);
    wait_out(cyc);
    checks++;
    if (cyc != 4) begin
      errors++;
      $display("FAIL %s_latency: %0d cycles required 4", name, cyc);
    end
    compare_result(name);
    release_out();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end else begin
      $display("reset: state ok");
    end
  endtask

  task automatic test_arith();
    run_op("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0);
    run_op("7fff_plus_1", 16'h7FFF, 16'h0001, 1'b0);
    run_op("1234_4321_c1", 16'h1234, 16'h4321, 1'b1);
    run_op("8000_8000", 16'h8000, 16'h8000, 1'b0);
  endtask

  task automatic test_backpressure();
    int cyc;
    exp_t e;
    accept(16'hA5A5, 16'h5A5B, 1'b0);
    wait_out(cyc);
    e = sb[0];
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (sum !== e.s || cout !== e.c || ovf !== e.o || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold%0d: sum=%h cout=%b ovf=%b in_ready=%b out_valid=%b required %h %b %b 0 1",
                 i, sum, cout, ovf, in_ready, out_valid, e.s, e.c, e.o);
      end
      tick();
    end
    compare_result("backpressure");
    release_out();
  endtask

  task automatic test_busy_input();
    int cyc;
    accept(16'h0102, 16'h0304, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    wait_out(cyc);
    compare_result("busy_input");
    release_out();
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL busy_no_second_op: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      end
    end
    run_op("after_busy", 16'h1111, 16'h2222, 1'b0);
  endtask

  task automatic test_reset_mid();
    accept(16'h1111, 16'h2222, 1'b0);
    tick(); tick();  // idx now 2
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(sb.pop_back());  // operation discarded by reset
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 16'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1 0 0000 0 0",
               in_ready, out_valid, sum, cout, ovf);
    end
    run_op("after_reset", 16'h0F0F, 16'h00F1, 1'b0);
    checks++;
    if (sum !== 16'h1000) begin
      errors++;
      $display("FAIL after_reset_sum: sum=%h required 1000", sum);
    end
  endtask

  task automatic test_back_to_back();
    int last_ready;
    int pushes;
    int pops;
    logic [15:0] x;
    logic [15:0] y;
    last_ready = -1;
    pushes = 0;
    pops = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && pops < 3; cyc++) begin
      if (out_valid) begin
        compare_result("back_to_back");
        pops++;
      end
      if (in_ready && in_valid) begin
        if (last_ready >= 0) begin
          checks++;
          if (cyc - last_ready != 6) begin
            errors++;
            $display("FAIL throughput: %0d cycles between accepts required 6", cyc - last_ready);
          end
        end
        last_ready = cyc;
        x = 16'($urandom);
        y = 16'($urandom);
        a = x; b = y; cin = pushes[0];
        sb.push_back(model(x, y, pushes[0]));
        pushes++;
        if (pushes == 3) begin
          tick();
          in_valid = 1'b0;
          continue;
        end
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (pops != 3 || sb.size() != 0) begin
      errors++;
      $display("FAIL back_to_back_count: results=%0d pending=%0d required 3 0", pops, sb.size());
    end
    tick();
  endtask

  task automatic test_width4();
    int cyc;
    w4_a = 4'hF; w4_b = 4'hF; w4_cin = 1'b1; w4_in_valid = 1'b1;
    tick();
    w4_in_valid = 1'b0;
    cyc = 0;
    while (!w4_out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 1 || w4_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL w4_latency: %0d cycles out_valid=%b required 1 1", cyc, w4_out_valid);
    end
    checks++;
    if (w4_sum !== 4'hF || w4_cout !== 1'b1 || w4_ovf !== 1'b0) begin
      errors++;
      $display("FAIL w4_result: sum=%h cout=%b ovf=%b required f 1 0", w4_sum, w4_cout, w4_ovf);
    end else begin
      $display("op w4: sum=%h cout=%b ovf=%b ok", w4_sum, w4_cout, w4_ovf);
    end
    w4_out_ready = 1'b1;
    tick();
    w4_out_ready = 1'b0;
    checks++;
    if (w4_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL w4_release: in_ready=%b required 1", w4_in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_busy_input();
    test_reset_mid();
    test_back_to_back();
    test_width4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
